// File: rtl/sub16_seq.sv
// Digit-serial subtractor: A - B - Bin, one DIGIT-bit slice per clock, with borrow/overflow/zero flags.
// Optional signed saturation of the result is enabled by defining SUB16_SAT_EN.
module sub16_seq #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf,
    output logic             zero,
    output logic [1:0]       o_dbg_state
);
    localparam int N    = WIDTH / DIGIT;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam int MSB  = WIDTH - 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_d;
    logic             r_brw;
    logic [IDXW-1:0]  r_idx;
    logic             r_bout;
    logic             r_ovf;
    logic             r_zero;

    logic [DIGIT-1:0] w_a_sl;
    logic [DIGIT-1:0] w_b_sl;
    logic [DIGIT-1:0] w_diff;
    logic             w_brw;
    logic [WIDTH-1:0] w_d_full;
    logic [WIDTH-1:0] w_d_final;
    logic             w_ovf;
    logic             w_last;
    int               w_base;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // One slice per cycle; w_d_full is the result with the current slice merged in.
    always_comb begin
        w_last   = (r_idx == LAST);
        w_base   = int'(r_idx) * DIGIT;
        w_a_sl   = r_a[w_base +: DIGIT];
        w_b_sl   = r_b[w_base +: DIGIT];
        {w_brw, w_diff} = {1'b0, w_a_sl} - {1'b0, w_b_sl} - (DIGIT + 1)'(r_brw);
        w_d_full = r_d;
        w_d_full[w_base +: DIGIT] = w_diff;
        w_ovf    = (r_a[MSB] != r_b[MSB]) && (w_d_full[MSB] != r_a[MSB]);
`ifdef SUB16_SAT_EN
        if (w_ovf)
            w_d_final = r_a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else
            w_d_final = w_d_full;
`else
        w_d_final = w_d_full;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_d    <= '0;
            r_brw  <= 1'b0;
            r_idx  <= '0;
            r_bout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_brw <= bin;
                        r_idx <= '0;
                    end
                end
                S_RUN: begin
                    r_brw <= w_brw;
                    if (w_last) begin
                        r_d    <= w_d_final;
                        r_idx  <= '0;
                        r_bout <= w_brw;
                        r_ovf  <= w_ovf;
                        r_zero <= (w_d_final == '0);
                    end else begin
                        r_d   <= w_d_full;
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready       = (r_state == S_IDLE);
    assign busy        = (r_state == S_RUN);
    assign done        = (r_state == S_DONE);
    assign d           = r_d;
    assign bout        = r_bout;
    assign ovf         = r_ovf;
    assign zero        = r_zero;
    assign o_dbg_state = r_state;
endmodule
